seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_pkg.sv | 40 ++++
 rtl/hex_to_seg.sv | 17 +
 rtl/seg_scan_ctrl.sv | 146 ++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg_pkg
//  Description : Shared types and constants for the 4-digit seven-segment
//                scan controller: scan FSM states, blanking values and the
//                active-low hex glyph table (bit 6 = a ... bit 0 = g).
//  Revision    : 1.0 - initial release
// ============================================================================
package seg_pkg;

   typedef enum logic [0:0] {
      BLANK = 1'b0,
      DRIVE = 1'b1
   } state_t;

   localparam logic [6:0] SEG_OFF = 7'h7F;
   localparam logic [3:0] AN_OFF  = 4'hF;

   // Active-low glyphs for hex digits 0..F, index 0 is the leftmost entry
   localparam logic [0:15][6:0] C_GLYPH_TABLE = {
      7'h01,  // 0
      7'h4F,  // 1
      7'h12,  // 2
      7'h06,  // 3
      7'h4C,  // 4
      7'h24,  // 5
      7'h20,  // 6
      7'h0F,  // 7
      7'h00,  // 8
      7'h04,  // 9
      7'h08,  // A
      7'h60,  // b
      7'h31,  // C
      7'h42,  // d
      7'h30,  // E
      7'h38   // F
   };

endpackage : seg_pkg
`default_nettype wire

// File: rtl/hex_to_seg.sv
`default_nettype none
// ============================================================================
//  Module      : hex_to_seg
//  Description : Combinational hex digit to active-low seven-segment glyph.
//  Revision    : 1.0 - initial release
// ============================================================================
module hex_to_seg
   import seg_pkg::*;
(
   input  logic [3:0] i_hex,
   output logic [6:0] o_seg
);

   assign o_seg = C_GLYPH_TABLE[i_hex];

endmodule : hex_to_seg
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_ctrl
//  Description : Time-multiplexed 4-digit seven-segment scan controller.
//                Each digit slot is a BLANK phase (all anodes off) followed
//                by a DRIVE phase. New display words are double-buffered in a
//                pending register and committed only at the end of the
//                digit3 drive slot so a frame never shows mixed data.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int unsigned REFRESH_DIV = 1000,
   parameter int unsigned BLANK_CYC   = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load_valid,
   input  logic [15:0] load_data,
   output logic        load_ready,
   input  logic [3:0]  digit_en,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        frame_done
);

   localparam logic [15:0] C_DRIVE_LAST = 16'(REFRESH_DIV - 1);
   localparam logic [15:0] C_BLANK_LAST = 16'(BLANK_CYC - 1);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [1:0]  r_idx;
   logic [1:0]  w_idx_nxt;
   logic [15:0] r_cnt;
   logic [15:0] w_cnt_nxt;
   logic        w_frame_end;

   logic [3:0]  r_an;
   logic [3:0]  w_an_nxt;
   logic [6:0]  r_seg;
   logic [6:0]  w_seg_nxt;
   logic        r_frame_done;
   logic        w_frame_done_nxt;

   logic [15:0] r_pending;
   logic [15:0] r_committed;
   logic        r_pend_valid;
   logic        w_load_fire;

   logic [3:0]  w_digit_nxt;
   logic [6:0]  w_glyph;

   // Scan state, digit index, slot counter and registered display outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= BLANK;
         r_idx        <= 2'd0;
         r_cnt        <= 16'd0;
         r_an         <= AN_OFF;
         r_seg        <= SEG_OFF;
         r_frame_done <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_idx        <= w_idx_nxt;
         r_cnt        <= w_cnt_nxt;
         r_an         <= w_an_nxt;
         r_seg        <= w_seg_nxt;
         r_frame_done <= w_frame_done_nxt;
      end
   end

   // Next-state logic: BLANK and DRIVE each run a fixed cycle count, the
   // counter restarts at every transition, the index advances leaving DRIVE
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_cnt_nxt   = r_cnt + 16'd1;
      w_frame_end = 1'b0;
      case (r_state)
         BLANK: begin
            if (r_cnt == C_BLANK_LAST) begin
               w_state_nxt = DRIVE;
               w_cnt_nxt   = 16'd0;
            end
         end
         DRIVE: begin
            if (r_cnt == C_DRIVE_LAST) begin
               w_state_nxt = BLANK;
               w_idx_nxt   = r_idx + 2'd1;
               w_cnt_nxt   = 16'd0;
               w_frame_end = (r_idx == 2'd3);
            end
         end
         default: begin
            w_state_nxt = BLANK;
            w_idx_nxt   = 2'd0;
            w_cnt_nxt   = 16'd0;
         end
      endcase
   end

   // Output decode looks at the next state so an/seg flip on the same edge
   // as the state; frame_done is high during the last digit3 drive cycle
   always_comb begin
      w_digit_nxt      = r_committed[{w_idx_nxt, 2'b00} +: 4];
      w_an_nxt         = AN_OFF;
      w_seg_nxt        = SEG_OFF;
      if ((w_state_nxt == DRIVE) && digit_en[w_idx_nxt]) begin
         w_an_nxt  = ~(4'b0001 << w_idx_nxt);
         w_seg_nxt = w_glyph;
      end
      w_frame_done_nxt = (w_state_nxt == DRIVE) && (w_idx_nxt == 2'd3) &&
                         (w_cnt_nxt == C_DRIVE_LAST);
   end

   hex_to_seg u_hex_to_seg (
      .i_hex (w_digit_nxt),
      .o_seg (w_glyph)
   );

   assign w_load_fire = load_valid & ~r_pend_valid;

   // Double buffer: accept into pending while empty, commit at frame end.
   // A full pending blocks loads, so commit and accept never coincide.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pending    <= 16'h0000;
         r_committed  <= 16'h0000;
         r_pend_valid <= 1'b0;
      end else if (w_frame_end && r_pend_valid) begin
         r_committed  <= r_pending;
         r_pend_valid <= 1'b0;
      end else if (w_load_fire) begin
         r_pending    <= load_data;
         r_pend_valid <= 1'b1;
      end
   end

   assign load_ready = ~r_pend_valid;
   assign an         = r_an;
   assign seg        = r_seg;
   assign frame_done = r_frame_done;

endmodule : seg_scan_ctrl
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg_scan_ctrl
//  Description : Self-checking bench for seg_scan_ctrl (REFRESH_DIV=8,
//                BLANK_CYC=2). Expected outputs come from a frame-position
//                model: position in frame -> slot and phase, plus a simple
//                pending/committed buffer model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_ctrl;

   localparam int R     = 8;
   localparam int B     = 2;
   localparam int SLOT  = R + B;
   localparam int FRAME = 4 * SLOT;

   logic        clk        = 1'b0;
   logic        reset      = 1'b1;
   logic        load_valid = 1'b0;
   logic [15:0] load_data  = 16'h0000;
   logic [3:0]  digit_en   = 4'hF;
   logic        load_ready;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        frame_done;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: cycle position within the frame plus buffer contents
   int          m_t    = 0;
   logic [15:0] m_com  = 16'h0000;
   logic [15:0] m_pend = 16'h0000;
   logic        m_pv   = 1'b0;
   logic [3:0]  m_en   = 4'hF;

   always #5 clk = ~clk;

   seg_scan_ctrl #(
      .REFRESH_DIV (R),
      .BLANK_CYC   (B)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .load_valid (load_valid),
      .load_data  (load_data),
      .load_ready (load_ready),
      .digit_en   (digit_en),
      .an         (an),
      .seg        (seg),
      .frame_done (frame_done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
      end
   endtask

   // Active-high abcdefg lit segments, inverted for the active-low display
   function automatic logic [6:0] ref_glyph(input logic [3:0] h);
      logic [6:0] lit;
      case (h)
         4'h0: lit = 7'b1111110;
         4'h1: lit = 7'b0110000;
         4'h2: lit = 7'b1101101;
         4'h3: lit = 7'b1111001;
         4'h4: lit = 7'b0110011;
         4'h5: lit = 7'b1011011;
         4'h6: lit = 7'b1011111;
         4'h7: lit = 7'b1110000;
         4'h8: lit = 7'b1111111;
         4'h9: lit = 7'b1111011;
         4'hA: lit = 7'b1110111;
         4'hB: lit = 7'b0011111;
         4'hC: lit = 7'b1001110;
         4'hD: lit = 7'b0111101;
         4'hE: lit = 7'b1001111;
         default: lit = 7'b1000111;
      endcase
      return ~lit;
   endfunction

   // One clock cycle: check this cycle's outputs, drive inputs for the next
   // edge, then advance the model across that edge
   task automatic step(input logic rst_i, input logic lv, input logic [15:0] ld,
                       input logic [3:0] en);
      int         p;
      int         slot;
      int         w;
      logic [3:0] e_an;
      logic [6:0] e_seg;
      logic       e_fd;
      @(negedge clk);
      p     = m_t % FRAME;
      slot  = p / SLOT;
      w     = p % SLOT;
      e_an  = 4'hF;
      e_seg = 7'h7F;
      if (w >= B && m_en[slot]) begin
         e_an  = ~(4'b0001 << slot);
         e_seg = ref_glyph(m_com[slot*4 +: 4]);
      end
      e_fd = (slot == 3) && (w == SLOT - 1);
      chk("an", 32'(an), 32'(e_an));
      chk("seg", 32'(seg), 32'(e_seg));
      chk("frame_done", 32'(frame_done), 32'(e_fd));
      chk("load_ready", 32'(load_ready), 32'(!m_pv));

      reset      = rst_i;
      load_valid = lv;
      load_data  = ld;
      digit_en   = en;

      m_en = en;
      if (rst_i) begin
         m_t    = 0;
         m_com  = 16'h0000;
         m_pend = 16'h0000;
         m_pv   = 1'b0;
      end else begin
         if (e_fd && m_pv) begin
            m_com = m_pend;
            m_pv  = 1'b0;
         end else if (lv && !m_pv) begin
            m_pend = ld;
            m_pv   = 1'b1;
         end
         m_t = (m_t + 1) % FRAME;
      end
   endtask

   initial begin
      logic        r_rst;
      logic        r_lv;
      logic [15:0] r_ld;
      logic [3:0]  r_en;

      // Reset, then idle scan showing 0000
      step(1'b1, 1'b0, 16'h0, 4'hF);
      step(1'b1, 1'b0, 16'h0, 4'hF);
      repeat (85) step(1'b0, 1'b0, 16'h0, 4'hF);

      // Single mid-frame load
      step(1'b0, 1'b1, 16'h1234, 4'hF);
      repeat (90) step(1'b0, 1'b0, 16'h0, 4'hF);

      // Back-to-back loads: second is held off until the boundary
      step(1'b0, 1'b1, 16'hAAAA, 4'hF);
      repeat (50) step(1'b0, 1'b1, 16'hBBBB, 4'hF);
      repeat (90) step(1'b0, 1'b0, 16'h0, 4'hF);

      // Load offered exactly in the last digit3 drive cycle, pending empty
      for (int k = 0; k < 2 * FRAME && (m_t != FRAME - 1 || m_pv); k++)
         step(1'b0, 1'b0, 16'h0, 4'hF);
      step(1'b0, 1'b1, 16'hC5E7, 4'hF);
      repeat (85) step(1'b0, 1'b0, 16'h0, 4'hF);

      // Digits 1 and 3 disabled
      repeat (80) step(1'b0, 1'b0, 16'h0, 4'b0101);

      // Reset during digit2 drive with a word pending
      for (int k = 0; k < 2 * FRAME && (m_t != 0 || m_pv); k++)
         step(1'b0, 1'b0, 16'h0, 4'hF);
      step(1'b0, 1'b1, 16'h9999, 4'hF);
      for (int k = 0; k < 2 * FRAME && m_t != 2 * SLOT + B + 3; k++)
         step(1'b0, 1'b0, 16'h0, 4'hF);
      step(1'b1, 1'b0, 16'h0, 4'hF);
      repeat (50) step(1'b0, 1'b0, 16'h0, 4'hF);

      // Randomized traffic: loads, data, enables and rare resets
      repeat (2000) begin
         r_rst = ($urandom_range(0, 299) == 0);
         r_lv  = ($urandom_range(0, 3) == 0);
         r_ld  = 16'($urandom);
         r_en  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
         step(r_rst, r_lv, r_ld, r_en);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_seg_scan_ctrl
`default_nettype wire
